// File: rtl/chip_74195_emu.sv
// Behavioural 74195 4-bit PIPO shift register for self-testing the chip checker.
// Pins are synchronised, Pin10 rising edges drive the core, outputs are registered with optional fault injection.
module chip_74195_emu #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Pin1,
  input  logic             Pin2,
  input  logic             Pin3,
  input  logic             Pin4,
  input  logic             Pin5,
  input  logic             Pin6,
  input  logic             Pin7,
  input  logic             Pin9,
  input  logic             Pin10,
  input  logic [1:0]       Fault_Mode,
  input  logic [2:0]       Fault_Sel,
  output logic             Pin15,
  output logic             Pin14,
  output logic             Pin13,
  output logic             Pin12,
  output logic             Pin11,
  output logic [CNT_W-1:0] Edge_Count
);

  localparam int IDX_CLR_N = 0;
  localparam int IDX_J     = 1;
  localparam int IDX_K_N   = 2;
  localparam int IDX_A     = 3;
  localparam int IDX_B     = 4;
  localparam int IDX_C     = 5;
  localparam int IDX_D     = 6;
  localparam int IDX_SHLD  = 7;
  localparam int IDX_CLK   = 8;

  logic [8:0]       pins_in;
  logic [8:0]       sync_q [SYNC_STAGES];
  logic [8:0]       s_pins;
  logic             clk_prev_q;
  logic             clk_rise;
  logic [3:0]       q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       raw_out;
  logic [4:0]       out_q, out_d;

  assign pins_in = {Pin10, Pin9, Pin7, Pin6, Pin5, Pin4, Pin3, Pin2, Pin1};
  assign s_pins  = sync_q[SYNC_STAGES-1];
  assign clk_rise = s_pins[IDX_CLK] & ~clk_prev_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pins_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // q_q[3] is QA, q_q[0] is QD; shifting moves data from QA toward QD.
  always_comb begin
    q_d = q_q;
    if (!s_pins[IDX_CLR_N]) begin
      q_d = '0;
    end else if (clk_rise) begin
      if (!s_pins[IDX_SHLD]) begin
        q_d = {s_pins[IDX_A], s_pins[IDX_B], s_pins[IDX_C], s_pins[IDX_D]};
      end else begin
        q_d[2:0] = q_q[3:1];
        case ({s_pins[IDX_J], s_pins[IDX_K_N]})
          2'b00:   q_d[3] = 1'b0;
          2'b11:   q_d[3] = 1'b1;
          2'b01:   q_d[3] = q_q[3];
          default: q_d[3] = ~q_q[3];
        endcase
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clk_rise && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  function automatic logic fault_bit(input logic b, input logic hit, input logic [1:0] mode);
    logic r;
    r = b;
    if (hit) begin
      case (mode)
        2'd1:    r = 1'b0;
        2'd2:    r = 1'b1;
        2'd3:    r = ~b;
        default: r = b;
      endcase
    end
    return r;
  endfunction

  // Bit 4 is Pin15 (QA) down to bit 0 Pin11 (QD_n); Fault_Sel k targets bit 4-k.
  always_comb begin
    raw_out = Reset ? 5'b00001 : {q_q, ~q_q[0]};
    out_d   = raw_out;
    for (int i = 0; i < 5; i++) begin
      out_d[i] = fault_bit(raw_out[i], Fault_Sel == 3'(4 - i), Fault_Mode);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      clk_prev_q <= 1'b0;
      q_q        <= '0;
      cnt_q      <= '0;
    end else begin
      clk_prev_q <= s_pins[IDX_CLK];
      q_q        <= q_d;
      cnt_q      <= cnt_d;
    end
    out_q <= out_d;
  end

  assign {Pin15, Pin14, Pin13, Pin12, Pin11} = out_q;
  assign Edge_Count = cnt_q;

endmodule
